// File: rtl/zx_pkg.sv
// Shared definitions for the MMCM reset sequencer: state encoding and counter width.
package zx_pkg;

    // Wide enough for every timing parameter the sequencer is expected to see.
    localparam int unsigned CNT_W = 20;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mmcm_reset_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous status bit.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmcm_reset_seq.sv
// Sequences MMCM reset, waits for a stable lock and holds downstream logic in reset
// until then; runs entirely on the board reference clock.
module mmcm_reset_seq
    import zx_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    output logic       mmcm_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [3:0] retries
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             lock_s;
    seq_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       retries_nx;

    sync2 u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d     (locked),
        .q     (lock_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= PLL_RST;
            cnt     <= '0;
            retries <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            retries <= retries_nx;
        end
    end

    // Lock loss is tested before any terminal count so RUN is never entered unlocked.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CNT_W'(1);
        retries_nx = retries;
        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nx = PLL_RST;
                    cnt_nx   = '0;
                    if (retries != 4'hF) begin
                        retries_nx = retries + 4'd1;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!lock_s) begin
                    state_nx = PLL_RST;
                end
            end
            default: begin
                state_nx = PLL_RST;
                cnt_nx   = '0;
            end
        endcase
    end

    assign mmcm_rst  = (state == PLL_RST);
    assign sys_reset = (state != RUN);
    assign ready     = (state == RUN);

endmodule
